// File: rtl/arb_pkg.sv
// Shared encodings for the shared-register arbiter: FSM states and write-op codes.
package arb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_LOCK  = 2'd2;

   localparam logic OP_LOAD = 1'b0;
   localparam logic OP_ADD  = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Round-robin scan: first set request starting at (ptr+1) mod N_REQ, wrapping.
module rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [PTR_W-1:0] winner,
   output logic             valid
);

   logic [PTR_W-1:0] idx;

   // Walk the ring from farthest to nearest so the nearest hit is the last write.
   always_comb begin
      winner = '0;
      idx    = '0;
      valid  = |req;
      for (int k = int'(N_REQ); k >= 1; k--) begin
         idx = PTR_W'((int'(ptr) + k) % int'(N_REQ));
         if (req[idx]) winner = idx;
      end
   end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter owning a shared register: per-requester load or saturating add,
// optional locked ownership bounded by MAX_LOCK, sticky overflow flag.
module shared_reg_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned MAX_LOCK = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ-1:0]        lock,
   input  logic [N_REQ-1:0]        wr_op,
   input  logic [N_REQ*DATA_W-1:0] wr_data,
   input  logic                    clr_ovf,
   output logic [N_REQ-1:0]        gnt,
   output logic [DATA_W-1:0]       reg_q,
   output logic                    ovf,
   output logic                    busy
);

   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

   logic [1:0]        state, state_nxt;
   logic [PTR_W-1:0]  winner, ptr, pick;
   logic              pick_vld;
   logic [CNT_W-1:0]  lock_cnt, lock_cnt_nxt;
   logic [N_REQ-1:0]  win_oh;
   logic [DATA_W-1:0] operand;
   logic [DATA_W:0]   sum;
   logic              commit;
   logic              ovf_set;

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req    (req),
      .ptr    (ptr),
      .winner (pick),
      .valid  (pick_vld)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Grant is masked by the live request so a dropped request never sees a grant.
   always_comb begin
      state_nxt    = state;
      lock_cnt_nxt = lock_cnt;
      gnt          = '0;
      case (state)
         ST_IDLE: begin
            if (pick_vld) state_nxt = ST_GRANT;
         end
         ST_GRANT: begin
            gnt = req & win_oh;
            if (lock[winner] && req[winner] && (MAX_LOCK > 1)) begin
               state_nxt    = ST_LOCK;
               lock_cnt_nxt = CNT_W'(1);
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_LOCK: begin
            gnt = req & win_oh;
            if (req[winner]) lock_cnt_nxt = lock_cnt + CNT_W'(1);
            if (!lock[winner] || !req[winner] || (lock_cnt_nxt >= CNT_W'(MAX_LOCK))) begin
               state_nxt    = ST_IDLE;
               lock_cnt_nxt = '0;
            end
         end
         default: begin
            state_nxt    = ST_IDLE;
            lock_cnt_nxt = '0;
         end
      endcase
   end

   always_comb begin
      operand = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (PTR_W'(i) == winner) operand = wr_data[i*DATA_W +: DATA_W];
      end
   end

   assign win_oh  = N_REQ'(1) << winner;
   assign sum     = {1'b0, reg_q} + {1'b0, operand};
   assign commit  = |gnt;
   assign ovf_set = commit && (wr_op[winner] == OP_ADD) && sum[DATA_W];
   assign busy    = (state != ST_IDLE);

   // Winner is frozen once chosen; ptr moves to it so the next scan starts past it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         winner   <= '0;
         ptr      <= PTR_W'(N_REQ - 1);
         lock_cnt <= '0;
         reg_q    <= '0;
         ovf      <= 1'b0;
      end else begin
         lock_cnt <= lock_cnt_nxt;
         if (state == ST_IDLE && pick_vld) winner <= pick;
         if (state == ST_GRANT) ptr <= winner;
         if (commit) begin
            case (wr_op[winner])
               OP_LOAD: reg_q <= operand;
               OP_ADD:  reg_q <= sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
               default: reg_q <= reg_q;
            endcase
         end
         ovf <= ovf_set | (ovf & ~clr_ovf);
      end
   end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter with hand-computed expectations.
module tb_shared_reg_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [3:0]  lock;
   logic [3:0]  wr_op;
   logic [31:0] wr_data;
   logic        clr_ovf;
   logic [3:0]  gnt;
   logic [7:0]  reg_q;
   logic        ovf;
   logic        busy;

   int n_cmp;
   int n_err;

   shared_reg_arbiter #(
      .N_REQ    (4),
      .DATA_W   (8),
      .MAX_LOCK (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .lock    (lock),
      .wr_op   (wr_op),
      .wr_data (wr_data),
      .clr_ovf (clr_ovf),
      .gnt     (gnt),
      .reg_q   (reg_q),
      .ovf     (ovf),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single requester write: one arbitration cycle, one grant cycle, commit at its end.
   task automatic do_write(input int r, input logic op, input logic [7:0] d, input logic clr);
      req     = 4'b0001 << r;
      wr_op   = op ? 4'b1111 : 4'b0000;
      wr_data = {4{d}};
      tick();
      chk("wr_gnt", 32'(gnt), 32'(4'b0001 << r));
      clr_ovf = clr;
      tick();
      req     = 4'b0000;
      clr_ovf = 1'b0;
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      rst     = 1'b1;
      req     = '0;
      lock    = '0;
      wr_op   = '0;
      wr_data = '0;
      clr_ovf = 1'b0;
      #3;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_reg", 32'(reg_q), 32'h0);
      chk("rst_ovf", 32'(ovf), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      tick();
      tick();
      rst = 1'b0;

      // Basic single load from requester 0
      req     = 4'b0001;
      wr_op   = 4'b0000;
      wr_data = 32'h0000_005A;
      tick();
      chk("t1_gnt", 32'(gnt), 32'h1);
      chk("t1_busy", 32'(busy), 32'h1);
      tick();
      chk("t1_gnt_off", 32'(gnt), 32'h0);
      chk("t1_reg", 32'(reg_q), 32'h5A);
      chk("t1_busy_off", 32'(busy), 32'h0);
      req = 4'b0000;

      // All requesters held: 0,1,2,3,0 with IDLE gaps
      rst = 1'b1;
      tick();
      rst     = 1'b0;
      req     = 4'b1111;
      wr_op   = 4'b0000;
      wr_data = {8'h13, 8'h12, 8'h11, 8'h10};
      for (int c = 0; c < 9; c++) begin
         tick();
         if (c % 2 == 0) chk("rr_gnt", 32'(gnt), 32'(4'b0001 << ((c / 2) % 4)));
         else begin
            chk("rr_gap", 32'(gnt), 32'h0);
            chk("rr_reg", 32'(reg_q), 32'h10 + 32'(c / 2));
         end
      end
      req = 4'b0000;
      tick();
      chk("rr_drop_gnt", 32'(gnt), 32'h0);
      chk("rr_drop_reg", 32'(reg_q), 32'h13);

      // Saturating add and sticky overflow
      do_write(0, 1'b0, 8'hF0, 1'b0);
      chk("ld_F0", 32'(reg_q), 32'hF0);
      chk("ld_F0_ovf", 32'(ovf), 32'h0);
      do_write(0, 1'b1, 8'h20, 1'b0);
      chk("sat_reg", 32'(reg_q), 32'hFF);
      chk("sat_ovf", 32'(ovf), 32'h1);
      do_write(0, 1'b1, 8'h01, 1'b1);
      chk("setwins_reg", 32'(reg_q), 32'hFF);
      chk("setwins_ovf", 32'(ovf), 32'h1);
      do_write(0, 1'b0, 8'h00, 1'b1);
      chk("clr_ovf", 32'(ovf), 32'h0);
      chk("clr_reg", 32'(reg_q), 32'h00);
      do_write(0, 1'b1, 8'h7F, 1'b0);
      chk("add_7F", 32'(reg_q), 32'h7F);
      do_write(0, 1'b1, 8'h80, 1'b0);
      chk("add_edge_reg", 32'(reg_q), 32'hFF);
      chk("add_edge_ovf", 32'(ovf), 32'h0);

      // Locked requester 2 with requester 1 waiting
      do_write(1, 1'b0, 8'h00, 1'b0);
      chk("lk_pre_reg", 32'(reg_q), 32'h00);
      req     = 4'b0110;
      lock    = 4'b0100;
      wr_op   = 4'b0100;
      wr_data = {8'h00, 8'h01, 8'hAA, 8'h00};
      for (int c = 0; c < 8; c++) begin
         tick();
         chk("lk_gnt", 32'(gnt), 32'h4);
      end
      tick();
      chk("lk_exit_gnt", 32'(gnt), 32'h0);
      chk("lk_exit_busy", 32'(busy), 32'h0);
      chk("lk_sum", 32'(reg_q), 32'h08);
      tick();
      chk("lk_next_gnt", 32'(gnt), 32'h2);
      tick();
      req  = 4'b0000;
      lock = 4'b0000;
      chk("lk_next_reg", 32'(reg_q), 32'hAA);

      // Reset in the middle of a locked burst
      req   = 4'b0100;
      lock  = 4'b0100;
      wr_op = 4'b0100;
      tick();
      tick();
      tick();
      chk("mr_gnt_pre", 32'(gnt), 32'h4);
      chk("mr_reg_pre", 32'(reg_q), 32'hAC);
      rst = 1'b1;
      #1;
      chk("mr_gnt", 32'(gnt), 32'h0);
      chk("mr_reg", 32'(reg_q), 32'h00);
      chk("mr_busy", 32'(busy), 32'h0);
      tick();
      req     = 4'b1010;
      lock    = 4'b0000;
      wr_op   = 4'b0000;
      wr_data = {8'h33, 8'h00, 8'h22, 8'h00};
      rst     = 1'b0;
      tick();
      chk("mr_first_gnt", 32'(gnt), 32'h2);
      tick();
      req = 4'b0000;
      chk("mr_first_reg", 32'(reg_q), 32'h22);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the register.
REQ-002 Parameter DATA_W, default 8, width of the shared register and write data.
REQ-003 Parameter MAX_LOCK, default 8, maximum consecutive locked grants before forced release.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  N_REQ  per-requester write request, held high until granted.
REQ-007 lock  input  N_REQ  per-requester request to keep ownership after the grant.
REQ-008 wr_op  input  N_REQ  per-requester operation: 0 = load, 1 = saturating add.
REQ-009 wr_data  input  N_REQ*DATA_W  per-requester operand, slice i belongs to requester i.
REQ-010 clr_ovf  input  1  clears the sticky overflow flag.
REQ-011 gnt  output  N_REQ  one-hot grant; the write commits on the edge that ends the grant cycle.
REQ-012 reg_q  output  DATA_W  shared register value; this block is its only driver.
REQ-013 ovf  output  1  sticky saturation flag.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states are IDLE, GRANT and LOCK; every case has an explicit default returning to IDLE, and no latches are inferred.
REQ-016 IDLE, any req high: latch winner = first set req scanning from (ptr+1) mod N_REQ upward with wrap; next state GRANT.
REQ-017 IDLE with no req high: stay IDLE, gnt = 0.
REQ-018 GRANT: gnt[winner] = 1 for exactly one cycle; ptr <= winner; the write commits at the end of that cycle.
REQ-019 GRANT exit: if lock[winner] and req[winner] are both high, go to LOCK with lock_cnt = 1; otherwise go to IDLE.
REQ-020 LOCK: gnt[winner] equals req[winner]; each cycle with gnt high commits a write and increments lock_cnt.
REQ-021 LOCK exit to IDLE: when lock[winner] = 0, or req[winner] = 0, or lock_cnt reaches MAX_LOCK after the committing cycle.
REQ-022 A forced exit lets other requesters win next arbitration because ptr = winner.
REQ-023 Load: reg_q <= operand.
REQ-024 Add: computed at DATA_W+1 bits; on carry-out, reg_q <= all ones and ovf <= 1; otherwise reg_q <= truncated sum.
REQ-025 ovf clears on clr_ovf only; if a new overflow coincides with clr_ovf, ovf = 1 (set wins).
REQ-026 Minimum latency from req rising in IDLE to gnt is 1 cycle; a non-locked grant is followed by at least one IDLE cycle.
REQ-027 gnt is never asserted for a requester whose req is low, and at most one gnt bit is high at any time.
REQ-028 Requests changing while in GRANT or LOCK do not alter winner.

Reset
REQ-029 rst asynchronously forces state = IDLE, gnt = 0, reg_q = 0, ovf = 0, busy = 0, lock_cnt = 0, and ptr = N_REQ-1, so requester 0 has first priority.
REQ-030 rst asserted mid-grant drops gnt immediately; the in-flight write is discarded.

Structure
REQ-031 The state encoding (IDLE = 2'd0, GRANT = 2'd1, LOCK = 2'd2) and the op encoding constants reside in the shared package arb_pkg.
REQ-032 The round-robin priority scan is a sub-module rr_pick (inputs req and ptr, outputs winner index and any-valid); all other logic lives in shared_reg_arbiter.

Verification
REQ-033 Reset, then req = 4'b0001, wr_op = 0, data0 = 8'h5A -> gnt = 4'b0001 one cycle later for one cycle; next cycle reg_q = 8'h5A, busy falls.
REQ-034 req = 4'b1111 held with no lock -> grants cycle in order 0,1,2,3,0 with an IDLE gap between grants.
REQ-035 reg_q = 8'hF0, add with 8'h20 -> reg_q = 8'hFF, ovf = 1; then clr_ovf together with another overflowing add -> ovf stays 1.
REQ-036 Requester 2 holds lock = 1 and req = 1 with add 8'h01, while req1 is also high -> exactly 8 consecutive gnt[2] cycles, then IDLE, then gnt[1].
REQ-037 rst asserted during LOCK -> gnt = 0 in the same cycle, reg_q = 0, next grant goes to the lowest set requester.
